unsigned_clz_divider: RTL
=========================

// Module: unsigned_clz_divider
// PURPOSE
//  Divider-side responder of the unsigned division interface: iterative radix-2 restoring divider.
//  Uses requester-supplied leading-zero counts to skip leading iterations.
//  Resolves divide-by-zero and divisor-larger-than-dividend in one cycle.
//  Sits under the div unit, which computes CLZ/zero flags, handles signs, and consumes quotient/remainder.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width (power of 2, >=8); CLZ fields are $clog2(DATA_WIDTH) bits
// PORTS
//  clk              in   1                  clock
//  rst              in   1                  synchronous, active-high reset
//  start            in   1                  request strobe; operands valid this cycle
//  dividend         in   DATA_WIDTH         unsigned dividend
//  dividend_CLZ     in   $clog2(DATA_WIDTH) leading zeros of dividend (DATA_WIDTH-1 when dividend==0)
//  divisor          in   DATA_WIDTH         unsigned divisor
//  divisor_CLZ      in   $clog2(DATA_WIDTH) leading zeros of divisor
//  divisor_is_zero  in   1                  divisor==0
//  quotient         out  DATA_WIDTH         result quotient
//  remainder        out  DATA_WIDTH         result remainder
//  done             out  1                  one-cycle pulse; results valid
// BEHAVIOUR
//  Interface: one clock (clk); reset (rst) synchronous, active-high.
//  Reset: state=IDLE; done=0; quotient=0; remainder=0; iteration counter=0.
//   Reset mid-operation aborts with no done pulse.
//  FSM states: IDLE, RUN, DONE.
//   start is accepted in IDLE or DONE; it is ignored in RUN.
//   No queuing: a start while busy is dropped, and the requester must not issue one.
//  On accepted start:
//   divisor_is_zero: quotient=all ones, remainder=dividend; -> DONE.
//   else if divisor_CLZ < dividend_CLZ: quotient=0, remainder=dividend; -> DONE.
//   else:
//    shift = divisor_CLZ - dividend_CLZ (unsigned, no underflow on this path).
//    Latch rem=dividend, d=divisor<<shift (never overflows), q=0, cnt=shift; -> RUN.
//  RUN, each cycle:
//   if rem >= d: rem -= d, q = {q[W-2:0],1}; else q = {q[W-2:0],0}.
//   Then d >>= 1 and cnt -= 1.
//   The iteration with cnt==0 is the last; -> DONE.
//   Compare is a full-width DATA_WIDTH+1 subtract; the borrow selects.
//  DONE: done=1 for exactly this cycle.
//   quotient/remainder hold the final values from this cycle until the next accepted start.
//   Next state: RUN if a start is accepted this cycle (back-to-back), else IDLE.
//  Latency, with start in cycle t:
//   special cases: done in cycle t+1.
//   general case: done in cycle t+shift+2 (shift+1 iterations); max DATA_WIDTH+1.
//  Outputs are registered; no combinational path from inputs to done/quotient/remainder.
//  Operand inputs are sampled only on the cycle of an accepted start.
//  CLZ inputs are trusted to be exact; incorrect CLZ gives undefined results (assertion in sim).
// TESTING
//  100/7 (CLZ 25/29, shift 4), start at t -> done pulse at t+6, quotient=14, remainder=2.
//  5/0 (divisor_is_zero=1) -> done at t+1, quotient=32'hFFFFFFFF, remainder=5.
//  3/10 (CLZ 30/28) -> done at t+1, quotient=0, remainder=3.
//  32'hFFFFFFFF/1 (CLZ 0/31) -> done at t+33, quotient=32'hFFFFFFFF, remainder=0.
//  0/9 (CLZ 31/28) -> done at t+1, quotient=0, remainder=0.
//  Start during RUN ignored, no extra done.
//  Back-to-back: start 20/3 in DONE cycle of prior op -> quotient=6, remainder=2 at correct latency.
//  rst asserted mid-RUN -> next cycle IDLE, outputs 0, no done.
//   A following 100/7 still completes correctly.
//  Random: 10k random operand pairs (incl. 0, 1, all ones) vs. reference model.
//   Check the done-latency formula on every operation.

Source files
------------

// File: rtl/unsigned_clz_divider.sv
// Iterative radix-2 restoring divider that uses the requester's leading-zero
// counts to skip leading iterations. Divide-by-zero and a divisor larger than
// the dividend finish in one cycle.
module unsigned_clz_divider #(
  parameter int DATA_WIDTH = 32,
  localparam int CW = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [CW-1:0]         dividend_CLZ,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic [CW-1:0]         divisor_CLZ,
  input  logic                  divisor_is_zero,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  done
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  rem;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          special;
  logic [CW-1:0] shift;
  logic [W:0]    diff;
  logic          borrow;
  logic [W-1:0]  rem_nxt;
  logic [W-1:0]  q_nxt;

  assign accept  = start && (state != RUN);
  assign special = divisor_is_zero || (divisor_CLZ < dividend_CLZ);
  assign shift   = divisor_CLZ - dividend_CLZ;

  // Full-width subtract; the borrow decides whether the trial succeeds.
  assign diff    = {1'b0, rem} - {1'b0, d};
  assign borrow  = diff[W];
  assign rem_nxt = borrow ? rem : diff[W-1:0];
  assign q_nxt   = (q << 1) | W'(!borrow);

  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: special cases skip RUN entirely.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start) state_nxt = special ? DONE : RUN;
      end
      RUN: begin
        if (cnt == '0) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem       <= '0;
      d         <= '0;
      q         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      if (divisor_is_zero) begin
        quotient  <= '1;
        remainder <= dividend;
      end else if (divisor_CLZ < dividend_CLZ) begin
        quotient  <= '0;
        remainder <= dividend;
      end else begin
        rem <= dividend;
        d   <= divisor << shift;
        q   <= '0;
        cnt <= shift;
      end
    end else if (state == RUN) begin
      rem <= rem_nxt;
      q   <= q_nxt;
      d   <= d >> 1;
      cnt <= cnt - CW'(1);
      if (cnt == '0) begin
        quotient  <= q_nxt;
        remainder <= rem_nxt;
      end
    end
  end

  function automatic logic [CW-1:0] clz_of(input logic [W-1:0] v);
    clz_of = CW'(W - 1);
    for (int i = 0; i < W; i++) begin
      if (v[i]) clz_of = CW'(W - 1 - i);
    end
  endfunction

  // Catch requesters that supply inexact CLZ or zero flags.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      assert (divisor_is_zero == (divisor == '0));
      assert (dividend_CLZ == clz_of(dividend));
      assert (divisor_is_zero || divisor_CLZ == clz_of(divisor));
    end
  end

endmodule
